// File: rtl/alu_cmd_sequencer.sv
// Initiator for a combinational ALU: registers one command at a time, captures the
// result one cycle later into an accumulator and an in-order response FIFO.
//
//   state  | meaning
//   S_IDLE | waiting for a command; accepts when the FIFO has room
//   S_EXEC | ALU inputs stable; result captured at the end of this cycle
module alu_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  input  logic             i_cmd_use_acc,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [2:0]       o_alu_op,
  input  logic [WIDTH-1:0] i_alu_result,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_zero,
  output logic [WIDTH-1:0] o_acc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_fifo_room;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;

  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic             r_mem_zero [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  assign w_fifo_room = (r_count < CW'(DEPTH));
  assign w_accept    = i_cmd_valid & o_cmd_ready;
  assign w_pop       = o_rsp_valid & i_rsp_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_cmd_valid && w_fifo_room) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE:  o_cmd_ready = w_fifo_room;
      S_EXEC:  w_push      = 1'b1;
      default: ;
    endcase
  end

  // Operand registers hold after EXEC so the ALU output stays stable between commands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (w_accept) begin
      r_alu_a  <= i_cmd_use_acc ? r_acc : i_cmd_a;
      r_alu_b  <= i_cmd_b;
      r_alu_op <= i_cmd_op;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_acc <= '0;
    else if (w_push) r_acc <= i_alu_result;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= i_alu_result;
      r_mem_zero[r_wr_ptr] <= (i_alu_result == '0);
    end
  end

  // Acceptance is gated on room, so a push never meets a full FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_op    = r_alu_op;
  assign o_acc       = r_acc;
  assign o_rsp_valid = (r_count != '0);
  assign o_rsp_data  = o_rsp_valid ? r_mem_data[r_rd_ptr] : '0;
  assign o_rsp_zero  = o_rsp_valid ? r_mem_zero[r_rd_ptr] : 1'b0;

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

- Initiator side of the 4-bit combinational ALU interface.
- Accepts operation commands over a valid/ready handshake and drives the ALU's A, B and op inputs from registers.
- Captures the ALU result one cycle later and returns it in order through a small response FIFO.
- Keeps an accumulator so a command can chain on the previous result. It sits between the control logic and the ALU datapath.

## Interface
Parameters:
- WIDTH, 4, operand/result width; must match the ALU (4).
- DEPTH, 4, response FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command this cycle.
- cmd_op  input  3  ALU opcode, passed through unchanged.
- cmd_a  input  WIDTH  operand A, used when cmd_use_acc=0.
- cmd_b  input  WIDTH  operand B.
- cmd_use_acc  input  1  1: use the accumulator as operand A instead of cmd_a.
- alu_a  output  WIDTH  registered operand A to the ALU.
- alu_b  output  WIDTH  registered operand B to the ALU.
- alu_op  output  3  registered opcode to the ALU.
- alu_result  input  WIDTH  combinational ALU output.
- rsp_valid  output  1  FIFO non-empty.
- rsp_ready  input  1  consumer takes the head entry.
- rsp_data  output  WIDTH  head entry result.
- rsp_zero  output  1  head entry result == 0.
- acc  output  WIDTH  last captured result.

## Operation
- **FSM states:** IDLE and EXEC.
- **IDLE:**
  - cmd_ready = 1 only when in IDLE and FIFO count < DEPTH.
  - On cmd_valid & cmd_ready: load alu_a (cmd_use_acc ? acc : cmd_a), alu_b = cmd_b and alu_op = cmd_op, then go to EXEC.
- **EXEC (exactly one cycle):**
  - cmd_ready = 0.
  - At the end of the cycle, sample alu_result: write it into acc and push {alu_result, alu_result==0} into the FIFO, then return to IDLE.
- **Register hold behaviour:**
  - alu_a, alu_b and alu_op hold their values after EXEC until the next accept.
  - The ALU output therefore stays stable, but it is sampled only in EXEC.
- **Opcodes:** the sequencer does not interpret them. The ALU defines 000 → 0, 001 add, 010 sub, 011 and, 100 or, 101 ~A, 110 ~B, 111 → 0.
- **Arithmetic:** WIDTH-bit modulo; wrap-around comes from the ALU and is passed unchanged, with no carry or borrow reported.
- **Accumulator:**
  - Updated only by EXEC captures.
  - A chained command reads the acc value present at its accept edge, which includes the immediately preceding command because that command finished EXEC before this accept.
- **FIFO:**
  - Circular buffer with a count register; rsp_valid = count != 0, and rsp_data/rsp_zero come from the head.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - rsp_ready while empty: ignored.
- **Overflow cannot occur:**
  - Acceptance requires count < DEPTH, and only one command is in flight at a time.
  - So the EXEC push always has room, even when no pop happens.
- **cmd_valid while cmd_ready = 0:** ignored. The command fields must be held by the producer (standard valid/ready protocol).
- **Reset (asserted any time, including mid-EXEC):**
  - Returns the FSM to IDLE, empties the FIFO and drops any in-flight command.
  - No response is produced for a dropped command.

## Timing
- **Reset values:**
  - cmd_ready = 1 (IDLE, FIFO empty).
  - alu_a = 0, alu_b = 0, alu_op = 000, acc = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_zero = 0.
- **Latency:** command accepted at edge N.
  - alu_a, alu_b and alu_op are valid after edge N.
  - The result is captured at edge N+1.
  - rsp_valid is high after edge N+1 when the FIFO was empty: two cycles from accept to response.
- **Throughput:** one command per 2 cycles maximum. cmd_ready is low during EXEC.
- **Pop timing:** a pop at edge M exposes the next entry after M.
- **Asynchronous reset:** takes effect immediately, not at the next edge.

## Test plan
1. **Reset:** drive rst_n=0 then release.
   - Required: all outputs at their reset values; cmd_ready=1 on the first edge after release.
2. **Single add:** cmd op=001, a=3, b=5.
   - Required: alu_op=001, alu_a=3, alu_b=5 after the accept edge; rsp_data=8, rsp_zero=0, acc=8 two edges after accept; rsp_valid drops after pop.
3. **Chain with wrap:** op=001, a=9, b=9, then op=010, use_acc=1, b=2.
   - Required: first rsp_data=2 (18 mod 16); second alu_a=2 and rsp_data=0 with rsp_zero=1; acc=0.
4. **Backpressure:** hold rsp_ready=0 and offer 5 commands (add 1+0, 2+0, 3+0, 4+0, 5+0).
   - Required: 4 accepted, then cmd_ready stays 0.
   - Then set rsp_ready=1: the FIFO drains 1, 2, 3, 4 in order, cmd_ready returns, and the 5th command yields 5.
5. **Simultaneous push/pop:** FIFO holds 1 entry; rsp_ready=1 in the same cycle as the EXEC push.
   - Required: count stays 1 and the new result becomes the head next cycle.
6. **Reset mid-op:** assert rst_n low during EXEC of op=011, a=F, b=6.
   - Required: no response, rsp_valid=0, acc=0, cmd_ready=1 after release.
